// File: rtl/wb_arbiter_unit_pkg.sv
// Shared types for the write-back arbiter: result source select, load funct3 codes,
// buffered long-latency entry layout and the load-data formatter.
package wb_arbiter_unit_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [REG_AW-1:0] rd;
        logic              fp;
    } ll_entry_t;

    // Unrecognised funct3 codes fall back to a full-word pass-through.
    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] word,
                                                 input logic [2:0]      f3,
                                                 input logic [1:0]      lsb);
        logic [XLEN-1:0] bsh;
        logic [XLEN-1:0] hsh;
        logic [XLEN-1:0] res;
        bsh = word >> {lsb, 3'b000};
        hsh = word >> {lsb[1], 4'b0000};
        case (f3)
            F3_LB:   res = {{(XLEN-8){bsh[7]}}, bsh[7:0]};
            F3_LBU:  res = {{(XLEN-8){1'b0}}, bsh[7:0]};
            F3_LH:   res = {{(XLEN-16){hsh[15]}}, hsh[15:0]};
            F3_LHU:  res = {{(XLEN-16){1'b0}}, hsh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_arbiter_unit_if.sv
// Bundle of pipe, long-latency and register-file write signals around the arbiter.
interface wb_arbiter_unit_if #(
    parameter int NUM_LL = 2
);
    import wb_arbiter_unit_pkg::*;

    logic                     pipe_valid;
    logic                     pipe_ready;
    wb_src_e                  pipe_src;
    logic [XLEN-1:0]          pipe_alu_data;
    logic [XLEN-1:0]          pipe_mem_data;
    logic [XLEN-1:0]          pipe_pc4;
    logic [2:0]               pipe_funct3;
    logic [1:0]               pipe_addr_lsb;
    logic [REG_AW-1:0]        pipe_rd;
    logic                     pipe_we;
    logic                     pipe_fp;
    logic [NUM_LL-1:0]        ll_valid;
    logic [NUM_LL-1:0]        ll_ready;
    logic [NUM_LL*XLEN-1:0]   ll_data;
    logic [NUM_LL*REG_AW-1:0] ll_rd;
    logic [NUM_LL-1:0]        ll_fp;
    logic [XLEN-1:0]          rdData;
    logic [REG_AW-1:0]        rdOut;
    logic                     writeEn;
    logic                     fwriteEn;
    logic                     ll_pending;

    modport slave (
        input  pipe_valid, pipe_src, pipe_alu_data, pipe_mem_data, pipe_pc4,
               pipe_funct3, pipe_addr_lsb, pipe_rd, pipe_we, pipe_fp,
               ll_valid, ll_data, ll_rd, ll_fp,
        output pipe_ready, ll_ready, rdData, rdOut, writeEn, fwriteEn, ll_pending
    );

    modport master (
        output pipe_valid, pipe_src, pipe_alu_data, pipe_mem_data, pipe_pc4,
               pipe_funct3, pipe_addr_lsb, pipe_rd, pipe_we, pipe_fp,
               ll_valid, ll_data, ll_rd, ll_fp,
        input  pipe_ready, ll_ready, rdData, rdOut, writeEn, fwriteEn, ll_pending
    );

endinterface

// File: rtl/wb_arbiter_unit_fifo.sv
// Small synchronous FIFO of long-latency results with a fall-through head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_arbiter_unit_fifo
    import wb_arbiter_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  ll_entry_t push_entry_i,
    output logic      full_o,
    output logic      empty_o,
    output ll_entry_t head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    ll_entry_t   mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
    end

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/wb_arbiter_unit.sv
// Write-back stage: merges the in-order pipe result with buffered long-latency
// results onto one registered register-file write port, with starvation guard.
module wb_arbiter_unit
    import wb_arbiter_unit_pkg::*;
#(
    parameter int NUM_LL        = 2,
    parameter int LL_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    wb_arbiter_unit_if.slave bus
);

    localparam int RRW = (NUM_LL > 1) ? $clog2(NUM_LL) : 1;
    localparam int SW  = $clog2(STARVE_LIMIT + 1);

    ll_entry_t         ll_in [NUM_LL];
    ll_entry_t         fifo_head;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic              force_ll, pipe_win;
    logic [RRW-1:0]    rr_q, rr_d, win_idx;
    logic              any_valid;
    logic [NUM_LL-1:0] ll_grant;
    logic [SW-1:0]     starve_q, starve_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic [REG_AW-1:0] rd_out_q, rd_out_d;
    logic              we_q, we_d, fwe_q, fwe_d;

    for (genvar gi = 0; gi < NUM_LL; gi++) begin : g_ll_unpack
        assign ll_in[gi].data = bus.ll_data[gi*XLEN +: XLEN];
        assign ll_in[gi].rd   = bus.ll_rd[gi*REG_AW +: REG_AW];
        assign ll_in[gi].fp   = bus.ll_fp[gi];
    end

    // A full FIFO, or a starved head, takes the port regardless of pipe_valid.
    assign force_ll       = fifo_full | (~fifo_empty & (starve_q == SW'(STARVE_LIMIT)));
    assign bus.pipe_ready = ~force_ll;
    assign pipe_win       = bus.pipe_valid & ~force_ll;
    assign fifo_pop       = force_ll | (~bus.pipe_valid & ~fifo_empty);

    // Scan from the farthest channel toward rr_q so the nearest valid one is kept.
    always_comb begin
        int             cand;
        logic [RRW-1:0] candi;
        cand      = 0;
        candi     = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        ll_grant  = '0;
        for (int k = NUM_LL - 1; k >= 0; k--) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_LL) cand = cand - NUM_LL;
            candi = RRW'(cand);
            if (bus.ll_valid[candi]) begin
                win_idx   = candi;
                any_valid = 1'b1;
            end
        end
        fifo_push = any_valid & (~fifo_full | fifo_pop);
        if (fifo_push) ll_grant[win_idx] = 1'b1;
        rr_d = rr_q;
        if (fifo_push) begin
            if (win_idx == RRW'(NUM_LL - 1)) rr_d = '0;
            else                             rr_d = win_idx + 1'b1;
        end
    end

    assign bus.ll_ready = ll_grant;

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop || fifo_empty)                           starve_d = '0;
        else if (pipe_win && starve_q != SW'(STARVE_LIMIT))   starve_d = starve_q + 1'b1;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_out_d  = rd_out_q;
        we_d      = 1'b0;
        fwe_d     = 1'b0;
        if (fifo_pop) begin
            rd_data_d = fifo_head.data;
            rd_out_d  = fifo_head.rd;
            we_d      = ~fifo_head.fp & (|fifo_head.rd);
            fwe_d     = fifo_head.fp;
        end else if (pipe_win) begin
            case (bus.pipe_src)
                WB_LOAD: rd_data_d = fmt_load(bus.pipe_mem_data, bus.pipe_funct3, bus.pipe_addr_lsb);
                WB_PC4:  rd_data_d = bus.pipe_pc4;
                default: rd_data_d = bus.pipe_alu_data;
            endcase
            rd_out_d = bus.pipe_rd;
            we_d     = bus.pipe_we & ~bus.pipe_fp & (|bus.pipe_rd);
            fwe_d    = bus.pipe_we & bus.pipe_fp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= '0;
            starve_q  <= '0;
            rd_data_q <= '0;
            rd_out_q  <= '0;
            we_q      <= 1'b0;
            fwe_q     <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            starve_q  <= starve_d;
            rd_data_q <= rd_data_d;
            rd_out_q  <= rd_out_d;
            we_q      <= we_d;
            fwe_q     <= fwe_d;
        end
    end

    wb_arbiter_unit_fifo #(.DEPTH(LL_FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (fifo_push),
        .pop_i        (fifo_pop),
        .push_entry_i (ll_in[win_idx]),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_o       (fifo_head)
    );

    assign bus.rdData     = rd_data_q;
    assign bus.rdOut      = rd_out_q;
    assign bus.writeEn    = we_q;
    assign bus.fwriteEn   = fwe_q;
    assign bus.ll_pending = ~fifo_empty;

endmodule

// File: tb/tb_wb_arbiter_unit.sv
// Directed bench for the write-back arbiter: load formatting, enables, round-robin,
// starvation, full-FIFO push-on-pop and asynchronous reset.
module tb_wb_arbiter_unit;
    import wb_arbiter_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_arbiter_unit_if #(.NUM_LL(2)) bus ();

    wb_arbiter_unit #(.NUM_LL(2), .LL_FIFO_DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_valid    = 1'b0;
        bus.pipe_src      = WB_ALU;
        bus.pipe_alu_data = '0;
        bus.pipe_mem_data = '0;
        bus.pipe_pc4      = '0;
        bus.pipe_funct3   = 3'b000;
        bus.pipe_addr_lsb = 2'b00;
        bus.pipe_rd       = '0;
        bus.pipe_we       = 1'b0;
        bus.pipe_fp       = 1'b0;
        bus.ll_valid      = '0;
        bus.ll_data       = '0;
        bus.ll_rd         = '0;
        bus.ll_fp         = '0;
    endtask

    task automatic pipe_alu(input logic [31:0] d, input logic [4:0] rd, input logic we, input logic fp);
        bus.pipe_valid    = 1'b1;
        bus.pipe_src      = WB_ALU;
        bus.pipe_alu_data = d;
        bus.pipe_rd       = rd;
        bus.pipe_we       = we;
        bus.pipe_fp       = fp;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.rdData !== 32'h0) begin failures++; $display("FAIL reset_rdData got=%h exp=%h", bus.rdData, 32'h0); end
        checks++; if (bus.rdOut !== 5'd0) begin failures++; $display("FAIL reset_rdOut got=%0d exp=0", bus.rdOut); end
        checks++; if ({bus.writeEn, bus.fwriteEn} !== 2'b00) begin failures++; $display("FAIL reset_enables got=%b exp=00", {bus.writeEn, bus.fwriteEn}); end
        checks++; if (bus.ll_pending !== 1'b0) begin failures++; $display("FAIL reset_ll_pending got=%b exp=0", bus.ll_pending); end
        checks++; if (bus.pipe_ready !== 1'b1) begin failures++; $display("FAIL reset_pipe_ready got=%b exp=1", bus.pipe_ready); end
        checks++; if (bus.ll_ready !== 2'b00) begin failures++; $display("FAIL reset_ll_ready got=%b exp=00", bus.ll_ready); end
        $display("txn reset rdData=%h rdOut=%0d we=%b fwe=%b", bus.rdData, bus.rdOut, bus.writeEn, bus.fwriteEn);
    endtask

    task automatic test_load_format();
        wb_src_e     src_t [12] = '{WB_LOAD, WB_LOAD, WB_LOAD, WB_LOAD, WB_LOAD, WB_LOAD,
                                    WB_LOAD, WB_LOAD, WB_LOAD, WB_LOAD, WB_PC4, WB_ALU};
        logic [2:0]  f3_t  [12] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b001, 3'b101,
                                    3'b101, 3'b000, 3'b010, 3'b011, 3'b000, 3'b000};
        logic [1:0]  lsb_t [12] = '{2, 2, 1, 2, 0, 0, 3, 3, 0, 0, 0, 0};
        logic [31:0] mem_t [12] = '{32'h1280_3456, 32'h1280_3456, 32'h1280_3456, 32'h1280_3456,
                                    32'hABCD_8001, 32'hABCD_8001, 32'hABCD_8001, 32'hABCD_8001,
                                    32'hABCD_8001, 32'hABCD_8001, 32'h5555_5555, 32'h5555_5555};
        logic [31:0] exp_t [12] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0034, 32'h0000_1280,
                                    32'hFFFF_8001, 32'h0000_8001, 32'h0000_ABCD, 32'hFFFF_FFAB,
                                    32'hABCD_8001, 32'hABCD_8001, 32'h0000_1004, 32'hDEAD_BEEF};
        logic [4:0]  exp_rd;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            exp_rd = 5'd5 + 5'(i);
            pipe_alu((i == 11) ? 32'hDEAD_BEEF : 32'h1111_1111, exp_rd, 1'b1, 1'b0);
            bus.pipe_src      = src_t[i];
            bus.pipe_mem_data = mem_t[i];
            bus.pipe_pc4      = 32'h0000_1004;
            bus.pipe_funct3   = f3_t[i];
            bus.pipe_addr_lsb = lsb_t[i];
            #1;
            checks++; if (bus.pipe_ready !== 1'b1) begin failures++; $display("FAIL load_pipe_ready[%0d] got=%b exp=1", i, bus.pipe_ready); end
            step();
            checks++; if (bus.rdData !== exp_t[i]) begin failures++; $display("FAIL load_data[%0d] got=%h exp=%h", i, bus.rdData, exp_t[i]); end
            checks++; if (bus.rdOut !== exp_rd || bus.writeEn !== 1'b1 || bus.fwriteEn !== 1'b0) begin
                failures++; $display("FAIL load_dest[%0d] got rd=%0d we=%b fwe=%b exp rd=%0d we=1 fwe=0", i, bus.rdOut, bus.writeEn, bus.fwriteEn, exp_rd);
            end
            $display("txn load[%0d] f3=%b lsb=%0d mem=%h rdData=%h rdOut=%0d", i, f3_t[i], lsb_t[i], mem_t[i], bus.rdData, bus.rdOut);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_enables();
        do_reset();
        pipe_alu(32'h0000_AAAA, 5'd0, 1'b1, 1'b0);
        step();
        checks++; if ({bus.writeEn, bus.fwriteEn} !== 2'b00) begin failures++; $display("FAIL en_x0_int got=%b exp=00", {bus.writeEn, bus.fwriteEn}); end
        $display("txn en x0 int we=%b fwe=%b", bus.writeEn, bus.fwriteEn);
        pipe_alu(32'h0000_BBBB, 5'd0, 1'b1, 1'b1);
        step();
        checks++; if ({bus.writeEn, bus.fwriteEn} !== 2'b01 || bus.rdData !== 32'h0000_BBBB) begin
            failures++; $display("FAIL en_f0 got we=%b fwe=%b data=%h exp we=0 fwe=1 data=0000bbbb", bus.writeEn, bus.fwriteEn, bus.rdData);
        end
        $display("txn en f0 we=%b fwe=%b data=%h", bus.writeEn, bus.fwriteEn, bus.rdData);
        pipe_alu(32'h0000_CCCC, 5'd7, 1'b0, 1'b0);
        step();
        checks++; if ({bus.writeEn, bus.fwriteEn} !== 2'b00) begin failures++; $display("FAIL en_we0 got=%b exp=00", {bus.writeEn, bus.fwriteEn}); end
        $display("txn en we0 we=%b fwe=%b", bus.writeEn, bus.fwriteEn);
        idle_inputs();
        step();
        checks++; if ({bus.writeEn, bus.fwriteEn} !== 2'b00 || bus.rdData !== 32'h0000_CCCC || bus.rdOut !== 5'd7) begin
            failures++; $display("FAIL en_idle_hold got we=%b fwe=%b data=%h rd=%0d exp 0 0 0000cccc 7", bus.writeEn, bus.fwriteEn, bus.rdData, bus.rdOut);
        end
        $display("txn idle hold data=%h rd=%0d", bus.rdData, bus.rdOut);
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [31:0] exp_d;
        logic [4:0]  exp_rd;
        int          k;
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            if (c < 4) begin
                bus.ll_valid = 2'b11;
                bus.ll_data  = {32'hB000_0000 + 32'(c), 32'hA000_0000 + 32'(c)};
                bus.ll_rd    = {5'd2, 5'd1};
                bus.ll_fp    = 2'b10;
            end else begin
                idle_inputs();
            end
            #1;
            if (c < 4) begin
                exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (bus.ll_ready !== exp_rdy) begin failures++; $display("FAIL rr_ll_ready[%0d] got=%b exp=%b", c, bus.ll_ready, exp_rdy); end
            end
            if (c == 1) begin
                checks++; if (bus.ll_pending !== 1'b1) begin failures++; $display("FAIL rr_pending got=%b exp=1", bus.ll_pending); end
            end
            step();
            if (c == 0) begin
                checks++; if ({bus.writeEn, bus.fwriteEn} !== 2'b00) begin failures++; $display("FAIL rr_first_idle got=%b exp=00", {bus.writeEn, bus.fwriteEn}); end
            end else begin
                k      = c - 1;
                exp_d  = (k % 2 == 1) ? 32'hB000_0000 + 32'(k) : 32'hA000_0000 + 32'(k);
                exp_rd = (k % 2 == 1) ? 5'd2 : 5'd1;
                checks++; if (bus.rdData !== exp_d || bus.rdOut !== exp_rd || bus.writeEn !== (k % 2 == 0) || bus.fwriteEn !== (k % 2 == 1)) begin
                    failures++; $display("FAIL rr_result[%0d] got data=%h rd=%0d we=%b fwe=%b exp data=%h rd=%0d", k, bus.rdData, bus.rdOut, bus.writeEn, bus.fwriteEn, exp_d, exp_rd);
                end
            end
            $display("txn rr cycle=%0d ll_ready=%b rdData=%h rdOut=%0d we=%b fwe=%b", c, bus.ll_ready, bus.rdData, bus.rdOut, bus.writeEn, bus.fwriteEn);
        end
        step();
        checks++; if ({bus.writeEn, bus.fwriteEn, bus.ll_pending} !== 3'b000) begin failures++; $display("FAIL rr_drained got=%b exp=000", {bus.writeEn, bus.fwriteEn, bus.ll_pending}); end
    endtask

    task automatic test_starvation();
        do_reset();
        bus.ll_valid = 2'b01;
        bus.ll_data  = {32'h0, 32'hC0DE_0001};
        bus.ll_rd    = {5'd0, 5'd9};
        step();
        checks++; if (bus.writeEn !== 1'b0) begin failures++; $display("FAIL starve_push_idle got=%b exp=0", bus.writeEn); end
        idle_inputs();
        for (int c = 1; c <= 6; c++) begin
            pipe_alu(32'h0000_0100 + 32'(c), 5'd3, 1'b1, 1'b0);
            #1;
            checks++; if (bus.pipe_ready !== (c != 5)) begin failures++; $display("FAIL starve_pipe_ready[%0d] got=%b exp=%b", c, bus.pipe_ready, (c != 5)); end
            step();
            if (c == 5) begin
                checks++; if (bus.rdData !== 32'hC0DE_0001 || bus.rdOut !== 5'd9 || bus.writeEn !== 1'b1) begin
                    failures++; $display("FAIL starve_ll_win got data=%h rd=%0d we=%b exp c0de0001 9 1", bus.rdData, bus.rdOut, bus.writeEn);
                end
            end else begin
                checks++; if (bus.rdData !== 32'h0000_0100 + 32'(c) || bus.rdOut !== 5'd3) begin
                    failures++; $display("FAIL starve_pipe_win[%0d] got data=%h rd=%0d exp %h 3", c, bus.rdData, bus.rdOut, 32'h0000_0100 + 32'(c));
                end
            end
            $display("txn starve cycle=%0d rdData=%h rdOut=%0d", c, bus.rdData, bus.rdOut);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            pipe_alu(32'h0000_0200 + 32'(c), 5'd4, 1'b1, 1'b0);
            bus.ll_valid = 2'b01;
            bus.ll_data  = {32'h0, 32'hE000_0000 + 32'(c)};
            bus.ll_rd    = {5'd0, 5'd10 + 5'(c)};
            #1;
            checks++; if (bus.pipe_ready !== (c != 4) || bus.ll_ready !== 2'b01) begin
                failures++; $display("FAIL full_ready[%0d] got pipe=%b ll=%b exp pipe=%b ll=01", c, bus.pipe_ready, bus.ll_ready, (c != 4));
            end
            step();
            if (c < 4) begin
                checks++; if (bus.rdData !== 32'h0000_0200 + 32'(c)) begin failures++; $display("FAIL full_pipe[%0d] got=%h exp=%h", c, bus.rdData, 32'h0000_0200 + 32'(c)); end
            end
            $display("txn full cycle=%0d pipe_ready=%b ll_ready=%b rdData=%h", c, bus.pipe_ready, bus.ll_ready, bus.rdData);
        end
        checks++; if (bus.rdData !== 32'hE000_0000 || bus.rdOut !== 5'd10) begin failures++; $display("FAIL full_head got data=%h rd=%0d exp e0000000 10", bus.rdData, bus.rdOut); end
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (bus.ll_pending !== 1'b1) begin failures++; $display("FAIL full_pending[%0d] got=%b exp=1", k, bus.ll_pending); end
            step();
            checks++; if (bus.rdData !== 32'hE000_0000 + 32'(k) || bus.rdOut !== 5'd10 + 5'(k) || bus.writeEn !== 1'b1) begin
                failures++; $display("FAIL full_drain[%0d] got data=%h rd=%0d we=%b exp %h %0d 1", k, bus.rdData, bus.rdOut, bus.writeEn, 32'hE000_0000 + 32'(k), 5'd10 + 5'(k));
            end
            $display("txn drain entry=%0d rdData=%h rdOut=%0d", k, bus.rdData, bus.rdOut);
        end
        checks++; if (bus.ll_pending !== 1'b0) begin failures++; $display("FAIL full_empty_after got=%b exp=0", bus.ll_pending); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            pipe_alu(32'h0000_0300 + 32'(c), 5'd4, 1'b1, 1'b0);
            bus.ll_valid = 2'b01;
            bus.ll_data  = {32'h0, 32'hF000_0000 + 32'(c)};
            bus.ll_rd    = {5'd0, 5'd12};
            step();
        end
        checks++; if (bus.rdData !== 32'h0000_0302 || bus.writeEn !== 1'b1 || bus.ll_pending !== 1'b1) begin
            failures++; $display("FAIL arst_pre got data=%h we=%b pend=%b exp 00000302 1 1", bus.rdData, bus.writeEn, bus.ll_pending);
        end
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++; if (bus.rdData !== 32'h0 || bus.rdOut !== 5'd0 || {bus.writeEn, bus.fwriteEn} !== 2'b00 || bus.ll_pending !== 1'b0) begin
            failures++; $display("FAIL arst_immediate got data=%h rd=%0d we=%b fwe=%b pend=%b exp all 0", bus.rdData, bus.rdOut, bus.writeEn, bus.fwriteEn, bus.ll_pending);
        end
        $display("txn async reset rdData=%h pend=%b", bus.rdData, bus.ll_pending);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if ({bus.writeEn, bus.fwriteEn, bus.ll_pending} !== 3'b000) begin
                failures++; $display("FAIL arst_no_stale[%0d] got=%b exp=000", c, {bus.writeEn, bus.fwriteEn, bus.ll_pending});
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_format();
        test_enables();
        test_round_robin();
        test_starvation();
        test_full_push_pop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
